// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one single-port memory with fixed read latency.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with round-robin between the ports.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    // instruction fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       own_d;
    logic       own_we;
    logic       gnt_i, gnt_d;
    logic       ack_now;
    logic       d_first;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // D wins a tie only when I was the most recent owner
    assign d_first = ~last_d;
`else
    assign d_first = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        ack_now   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (d_req && (d_first || !i_req)) begin
                        gnt_d = 1'b1;
                    end else if (i_req) begin
                        gnt_i = 1'b1;
                    end
                    if (gnt_i || gnt_d) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAT4) begin
                    ack_now   = ~rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            own_d  <= 1'b0;
            own_we <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (gnt_i || gnt_d) begin
                cnt    <= 4'd1;
                own_d  <= gnt_d;
                own_we <= gnt_d & d_we;
`ifdef ARB_ROUND_ROBIN_EN
                last_d <= gnt_d;
`endif
            end else if (ack_now) begin
                cnt <= 4'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // memory command is only non-zero in the grant cycle
    always_comb begin
        i_gnt     = gnt_i;
        d_gnt     = gnt_d;
        mem_en    = gnt_i | gnt_d;
        mem_we    = gnt_d & d_we;
        mem_addr  = gnt_d ? d_addr : (gnt_i ? i_addr : '0);
        mem_wdata = gnt_d ? d_wdata : '0;
        i_ack     = ack_now & ~own_d;
        d_ack     = ack_now & own_d;
        i_rdata   = i_ack ? mem_rdata : '0;
        d_rdata   = (d_ack && !own_we) ? mem_rdata : '0;
        busy      = (state == WAIT) && !rst;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand-written contention, stall and reset sequences.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic drive(input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
    endtask

    // checks the grant-cycle outputs and queues the matching ack
    task automatic issue(input string nm, input bit exp_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_exp);
        chk({nm, "_i_gnt"}, i_gnt, !exp_d);
        chk({nm, "_d_gnt"}, d_gnt, exp_d);
        chk({nm, "_mem_en"}, mem_en, 1);
        chk({nm, "_mem_we"}, mem_we, exp_d & we);
        chk({nm, "_mem_addr"}, mem_addr, addr);
        chk({nm, "_mem_wdata"}, mem_wdata, exp_d ? wdata : 32'h0);
        chk({nm, "_busy_issue"}, busy, 0);
        sb.push_back('{is_d: exp_d, rdata: (exp_d && we) ? 32'h0 : rd_exp, due: cyc + LAT});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet_cycle(input string nm, input bit exp_busy);
        chk({nm, "_busy"}, busy, exp_busy);
        chk({nm, "_mem_en"}, mem_en, 0);
        chk({nm, "_gnt"}, {i_gnt, d_gnt}, 0);
        chk({nm, "_mem_cmd"}, {mem_we, mem_addr, mem_wdata}, 0);
    endtask

    // ack scoreboard plus mutual-exclusion checks, every cycle
    always begin
        @(negedge clk);
        #1;
        chk("ack_excl", i_ack & d_ack, 0);
        chk("gnt_excl", i_gnt & d_gnt, 0);
        if (!i_ack) chk("i_rdata_zero", i_rdata, 0);
        if (!d_ack) chk("d_rdata_zero", d_rdata, 0);
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack cycle %0d i_ack %0b d_ack %0b", cyc, i_ack, d_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", d_ack, e.is_d);
                chk("ack_cycle", cyc, e.due);
                chk("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    initial begin
        bit   exp_d;
        vec_t vi, vd;

        vecs[0] = '{is_d: 1'b1, we: 1'b1, addr: 32'h40,  wdata: 32'hDEADBEEF, rdata: 32'h5555AAAA};
        vecs[1] = '{is_d: 1'b0, we: 1'b0, addr: 32'h204, wdata: 32'h0,        rdata: 32'h13579BDF};
        vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h88,  wdata: 32'h0,        rdata: 32'hFFFFFFFF};
        vecs[3] = '{is_d: 1'b1, we: 1'b1, addr: 32'hFFFFFFFC, wdata: 32'h1,   rdata: 32'h0BADF00D};
        vecs[4] = '{is_d: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0,        rdata: 32'h24020005};
        vi = '{is_d: 1'b0, we: 1'b0, addr: 32'h200, wdata: 32'h0, rdata: 32'h0};
        vd = '{is_d: 1'b1, we: 1'b0, addr: 32'h300, wdata: 32'h0, rdata: 32'h0};

        // reset with both requests pending: everything must stay quiet
        rst = 1'b1;
        idle_inputs();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h77; i_addr = 32'h66;
        mem_rdata = 32'h12345678;
        repeat (3) begin
            step();
            quiet_cycle("reset", 0);
            chk("reset_acks", {i_ack, d_ack}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        quiet_cycle("post_reset", 0);

        // single transactions
        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n]);
            mem_rdata = vecs[n].rdata;
            #1;
            issue($sformatf("vec%0d", n), vecs[n].is_d, vecs[n].we, vecs[n].addr,
                  vecs[n].wdata, vecs[n].rdata);
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                idle_inputs();
                #1;
                quiet_cycle($sformatf("vec%0d_wait", n), 1);
            end
            step();
            quiet_cycle($sformatf("vec%0d_after", n), 0);
        end

        // simultaneous requests: D first, I after the D transaction
        mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        drive(vi); drive(vd);
        #1;
        issue("cont_d", 1, 0, vd.addr, vd.wdata, 32'hCAFE0001);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            d_req = 1'b0;
            #1;
            chk("cont_i_held_off", i_gnt, 0);
            chk("cont_busy", busy, 1);
        end
        step();
        issue("cont_i", 0, 0, vi.addr, 32'h0, 32'hCAFE0001);
        @(negedge clk);
        idle_inputs();
        repeat (LAT) step();

        // I request arriving while D is in flight
        mem_rdata = 32'h0F0F0F0F;
        @(negedge clk);
        drive(vd);
        #1;
        issue("stall_d", 1, 0, vd.addr, 32'h0, 32'h0F0F0F0F);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            d_req = 1'b0;
            drive(vi);
            #1;
            chk("stall_i_gnt", i_gnt, 0);
        end
        step();
        issue("stall_i", 0, 0, vi.addr, 32'h0, 32'h0F0F0F0F);
        @(negedge clk);
        idle_inputs();
        repeat (LAT) step();

        // both requests held continuously for four grants
        mem_rdata = 32'h600DD00D;
        @(negedge clk);
        drive(vi); drive(vd);
        for (int g = 0; g < 4; g++) begin
            if (g != 0) @(negedge clk);
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            issue($sformatf("hold%0d", g), exp_d, 0, exp_d ? vd.addr : vi.addr, 32'h0, 32'h600DD00D);
            for (int k = 1; k <= LAT; k++) begin
                step();
                chk($sformatf("hold%0d_no_gnt", g), {i_gnt, d_gnt}, 0);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        repeat (LAT) step();

        // reset in the middle of a D read aborts it; a held request wins right after
        mem_rdata = 32'h0000BEEF;
        @(negedge clk);
        drive(vd);
        #1;
        issue("abort_d", 1, 0, vd.addr, 32'h0, 32'h0000BEEF);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        #1;
        quiet_cycle("abort_rst", 0);
        chk("abort_rst_ack", d_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_no_ack", d_ack, 0);
        issue("abort_regrant", 1, 0, vd.addr, 32'h0, 32'h0000BEEF);
        @(negedge clk);
        idle_inputs();
        #1;
        repeat (LAT + 2) step();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 32, meaning address width.
REQ-002 The module SHALL have parameter DW, default 32, meaning data width.
REQ-003 The module SHALL have parameter MEM_LAT, default 2, legal range 1..15, meaning cycles from mem_en to valid mem_rdata.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 The module SHALL have the instruction-fetch port: i_req in 1 fetch request; i_addr in AW; i_gnt out 1 accepted; i_ack out 1 data valid; i_rdata out DW.
REQ-006 The module SHALL have the data port: d_req in 1; d_we in 1 write when 1; d_addr in AW; d_wdata in DW; d_gnt out 1; d_ack out 1 complete; d_rdata out DW.
REQ-007 The module SHALL have the memory port: mem_en out 1; mem_we out 1; mem_addr out AW; mem_wdata out DW; mem_rdata in DW.
REQ-008 The module SHALL have busy out 1, meaning a transaction is in flight.

Function
REQ-009 The arbiter SHALL share one single-port memory between the I and D ports, with at most one transaction outstanding.
REQ-010 The FSM SHALL have states IDLE and WAIT; IDLE->WAIT on any grant; WAIT->IDLE on the ack cycle.
REQ-011 In IDLE with any req high, the winner's gnt and mem_en SHALL assert combinationally in that same cycle for exactly one cycle, with mem_addr/mem_we/mem_wdata driven from the winner (mem_we=0 for I).
REQ-012 When mem_en=0, mem_we, mem_addr and mem_wdata SHALL be driven to 0.
REQ-013 WAIT SHALL count cycles after issue with a 4-bit counter; the owner's ack SHALL pulse once in cycle issue+MEM_LAT, with x_rdata=mem_rdata in that cycle; otherwise x_rdata=0.
REQ-014 The next grant SHALL occur no earlier than cycle issue+MEM_LAT+1, giving a peak throughput of one transaction per MEM_LAT+1 cycles.
REQ-015 busy SHALL be 1 from issue+1 through issue+MEM_LAT inclusive, and 0 otherwise.
REQ-016 A requester SHALL hold req and its fields stable until gnt; dropping req before gnt SHALL withdraw the request with no side effect.
REQ-017 A req raised or held during WAIT SHALL receive no gnt until the state returns to IDLE.
REQ-018 On simultaneous requests in IDLE without round-robin, D SHALL win.
REQ-019 d_ack SHALL pulse for both reads and writes; d_rdata SHALL be 0 on write acks.
REQ-020 i_ack and d_ack SHALL never assert in the same cycle, and i_gnt and d_gnt SHALL never assert in the same cycle.

Reset
REQ-021 While rst=1, state SHALL be IDLE, the counter 0, and all outputs 0, including combinational gnt and mem_en.
REQ-022 rst during WAIT SHALL abort the transaction: no ack issued, busy=0 next cycle.
REQ-023 The first grant after reset SHALL be possible in the first cycle with rst=0.
REQ-024 The round-robin last-owner register SHALL reset to I.

Configuration
REQ-025 With macro ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port not granted most recently SHALL win; last-owner SHALL update on every grant.
REQ-026 Without ARB_ROUND_ROBIN_EN, fixed D-over-I priority SHALL apply and no last-owner register SHALL exist.

Verification (MEM_LAT=2, issue cycle = 0)
REQ-027 I-only: i_req=1, i_addr=0x100 at cycle 0 -> i_gnt=1, mem_en=1, mem_addr=0x100 in cycle 0; busy in cycles 1-2; i_ack=1 in cycle 2, i_rdata=mem_rdata=0x24020005.
REQ-028 D write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 with those values in cycle 0; d_ack in cycle 2, d_rdata=0; i_gnt stays 0.
REQ-029 Fixed priority contention: i_req and d_req both high from cycle 0 -> d_gnt in cycle 0, d_ack in cycle 2, i_gnt in cycle 3, i_ack in cycle 5.
REQ-030 ARB_ROUND_ROBIN_EN, both reqs held continuously -> grants D, I, D, I in cycles 0, 3, 6, 9.
REQ-031 rst=1 in cycle 1 of a D read -> no d_ack in cycle 2, busy=0; a request present at rst deassertion is granted in that first cycle with rst=0.
REQ-032 i_req rising in cycle 1 during a D transaction -> no i_gnt in cycles 1-2; i_gnt in cycle 3.
